// File: rtl/mult_issue_queue.sv
// In-order issue queue feeding the multiplier: buffers dispatched ops, wakes operands from the CDB,
// issues the head once both operands are final. Optional same-cycle bypass: define MULT_IQ_BYPASS_EN.
module mult_issue_queue #(
    parameter int DEPTH  = 4,
    parameter int TAG_W  = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              dispatch_en,
    input  logic [DATA_W-1:0] d_rs1_data,
    input  logic [TAG_W-1:0]  d_rs1_tag,
    input  logic              d_rs1_valid,
    input  logic [DATA_W-1:0] d_rs2_data,
    input  logic [TAG_W-1:0]  d_rs2_tag,
    input  logic              d_rs2_valid,
    input  logic [TAG_W-1:0]  d_rd_tag,
    output logic              queue_full,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              exec_ready,
    output logic              issue_valid,
    output logic [DATA_W-1:0] issue_rs1_data,
    output logic [DATA_W-1:0] issue_rs2_data,
    output logic [TAG_W-1:0]  issue_rd_tag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [DEPTH-1:0]  ent_valid_r;
    logic [DEPTH-1:0]  rs1_valid_r;
    logic [DEPTH-1:0]  rs2_valid_r;
    logic [DATA_W-1:0] rs1_data_r [DEPTH];
    logic [DATA_W-1:0] rs2_data_r [DEPTH];
    logic [TAG_W-1:0]  rs1_tag_r  [DEPTH];
    logic [TAG_W-1:0]  rs2_tag_r  [DEPTH];
    logic [TAG_W-1:0]  rd_tag_r   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;

    logic              full_s;
    logic              head_ready_s;
    logic              push_s;
    logic              pop_s;
    logic              bypass_s;
    logic              d_rs1_hit_s;
    logic              d_rs2_hit_s;
    logic [DATA_W-1:0] d_rs1_fin_s;
    logic [DATA_W-1:0] d_rs2_fin_s;

    // Queue status, push-time CDB capture and push/pop/bypass qualification
    always_comb begin
        full_s       = (count_r == DEPTH_C);
        head_ready_s = ent_valid_r[rd_ptr_r] & rs1_valid_r[rd_ptr_r] & rs2_valid_r[rd_ptr_r];
        d_rs1_hit_s  = cdb_valid & ~d_rs1_valid & (cdb_tag == d_rs1_tag);
        d_rs2_hit_s  = cdb_valid & ~d_rs2_valid & (cdb_tag == d_rs2_tag);
        if (d_rs1_hit_s) begin
            d_rs1_fin_s = cdb_data;
        end else begin
            d_rs1_fin_s = d_rs1_data;
        end
        if (d_rs2_hit_s) begin
            d_rs2_fin_s = cdb_data;
        end else begin
            d_rs2_fin_s = d_rs2_data;
        end
`ifdef MULT_IQ_BYPASS_EN
        bypass_s = (count_r == '0) & ~flush & dispatch_en & exec_ready
                 & (d_rs1_valid | d_rs1_hit_s) & (d_rs2_valid | d_rs2_hit_s);
`else
        bypass_s = 1'b0;
`endif
        // A full queue refuses the push even when the head pops in the same cycle
        push_s = dispatch_en & ~full_s & ~flush & ~bypass_s;
        pop_s  = head_ready_s & exec_ready & ~flush;
    end

    // Issue port: head entry normally, dispatch inputs when bypassing an empty queue
    always_comb begin
        queue_full = full_s;
        if (bypass_s) begin
            issue_valid    = 1'b1;
            issue_rs1_data = d_rs1_fin_s;
            issue_rs2_data = d_rs2_fin_s;
            issue_rd_tag   = d_rd_tag;
        end else begin
            issue_valid    = head_ready_s;
            issue_rs1_data = rs1_data_r[rd_ptr_r];
            issue_rs2_data = rs2_data_r[rd_ptr_r];
            issue_rd_tag   = rd_tag_r[rd_ptr_r];
        end
    end

    // Entry storage, CDB snoop, pointers and occupancy count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_valid_r <= '0;
            rs1_valid_r <= '0;
            rs2_valid_r <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rs1_data_r[i] <= '0;
                rs2_data_r[i] <= '0;
                rs1_tag_r[i]  <= '0;
                rs2_tag_r[i]  <= '0;
                rd_tag_r[i]   <= '0;
            end
        end else if (flush) begin
            ent_valid_r <= '0;
            rs1_valid_r <= '0;
            rs2_valid_r <= '0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (ent_valid_r[i] && cdb_valid && !rs1_valid_r[i] && (rs1_tag_r[i] == cdb_tag)) begin
                    rs1_data_r[i]  <= cdb_data;
                    rs1_valid_r[i] <= 1'b1;
                end
                if (ent_valid_r[i] && cdb_valid && !rs2_valid_r[i] && (rs2_tag_r[i] == cdb_tag)) begin
                    rs2_data_r[i]  <= cdb_data;
                    rs2_valid_r[i] <= 1'b1;
                end
            end
            if (pop_s) begin
                ent_valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r              <= rd_ptr_r + PTR_W'(1);
            end
            // Push slot is never occupied, so it cannot collide with the snoop above
            if (push_s) begin
                ent_valid_r[wr_ptr_r] <= 1'b1;
                rs1_valid_r[wr_ptr_r] <= d_rs1_valid | d_rs1_hit_s;
                rs2_valid_r[wr_ptr_r] <= d_rs2_valid | d_rs2_hit_s;
                rs1_data_r[wr_ptr_r]  <= d_rs1_fin_s;
                rs2_data_r[wr_ptr_r]  <= d_rs2_fin_s;
                rs1_tag_r[wr_ptr_r]   <= d_rs1_tag;
                rs2_tag_r[wr_ptr_r]   <= d_rs2_tag;
                rd_tag_r[wr_ptr_r]    <= d_rd_tag;
                wr_ptr_r              <= wr_ptr_r + PTR_W'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_issue_queue.sv
// Scoreboard bench for mult_issue_queue: stimulus queues expected issues, a negedge monitor checks them.
module tb_mult_issue_queue;

    logic        clk = 1'b0;
    logic        rst_n, flush, dispatch_en, exec_ready, cdb_valid;
    logic [31:0] d_rs1_data, d_rs2_data, cdb_data;
    logic [5:0]  d_rs1_tag, d_rs2_tag, d_rd_tag, cdb_tag;
    logic        d_rs1_valid, d_rs2_valid;
    logic        queue_full, issue_valid;
    logic [31:0] issue_rs1_data, issue_rs2_data;
    logic [5:0]  issue_rd_tag;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [5:0]  rd;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    mult_issue_queue #(.DEPTH(4), .TAG_W(6), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .dispatch_en(dispatch_en),
        .d_rs1_data(d_rs1_data), .d_rs1_tag(d_rs1_tag), .d_rs1_valid(d_rs1_valid),
        .d_rs2_data(d_rs2_data), .d_rs2_tag(d_rs2_tag), .d_rs2_valid(d_rs2_valid),
        .d_rd_tag(d_rd_tag), .queue_full(queue_full),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .exec_ready(exec_ready), .issue_valid(issue_valid),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data),
        .issue_rd_tag(issue_rd_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted issue must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && issue_valid && exec_ready && !flush) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_issue actual=tag%0h required=none", issue_rd_tag);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (issue_rs1_data !== e.rs1 || issue_rs2_data !== e.rs2 || issue_rd_tag !== e.rd) begin
                    errors++;
                    $display("FAIL issue actual=%0h/%0h/tag%0h required=%0h/%0h/tag%0h",
                             issue_rs1_data, issue_rs2_data, issue_rd_tag, e.rs1, e.rs2, e.rd);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one dispatch cycle; exp_en queues the hand-computed expected issue
    task automatic push(input logic [31:0] r1, input logic [5:0] t1, input logic v1,
                        input logic [31:0] r2, input logic [5:0] t2, input logic v2,
                        input logic [5:0] rd, input bit exp_en,
                        input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        d_rs1_data = r1; d_rs1_tag = t1; d_rs1_valid = v1;
        d_rs2_data = r2; d_rs2_tag = t2; d_rs2_valid = v2;
        d_rd_tag = rd; dispatch_en = 1'b1;
        if (exp_en) begin
            e.rs1 = e1; e.rs2 = e2; e.rd = rd;
            sbq.push_back(e);
        end
        step();
        dispatch_en = 1'b0; d_rs1_valid = 1'b0; d_rs2_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; dispatch_en = 1'b0; exec_ready = 1'b0;
        cdb_valid = 1'b0; cdb_tag = 6'd0; cdb_data = 32'd0;
        d_rs1_data = 32'd0; d_rs2_data = 32'd0; d_rs1_tag = 6'd0; d_rs2_tag = 6'd0;
        d_rs1_valid = 1'b0; d_rs2_valid = 1'b0; d_rd_tag = 6'd0;
        step(); step();
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_queue_full", 64'(queue_full), 64'd0);
        chk("rst_issue_data", {issue_rs1_data, issue_rs2_data}, 64'd0);
        chk("rst_rd_tag", 64'(issue_rd_tag), 64'd0);
        rst_n = 1'b1;
        step();

        // Basic push and issue one cycle later
        exec_ready = 1'b1;
        push(32'd5, 6'd0, 1'b1, 32'd7, 6'd0, 1'b1, 6'd3, 1'b1, 32'd5, 32'd7);
`ifdef MULT_IQ_BYPASS_EN
        chk("bypass_not_stored", 64'(issue_valid), 64'd0);
`else
        chk("latency_1", 64'(issue_valid), 64'd1);
`endif
        step();
        chk("popped", 64'(issue_valid), 64'd0);

        // CDB wake of a pending rs1; a non-matching tag must not wake it
        push(32'd0, 6'd9, 1'b0, 32'h22, 6'd0, 1'b1, 6'd4, 1'b1, 32'h1234, 32'h22);
        chk("wait_operand", 64'(issue_valid), 64'd0);
        cdb_valid = 1'b1; cdb_tag = 6'd10; cdb_data = 32'hDEAD;
        step();
        cdb_tag = 6'd9; cdb_data = 32'h1234;
        #1;
        chk("no_wrong_wake", 64'(issue_valid), 64'd0);
        step();
        cdb_valid = 1'b0;
        chk("woken", 64'(issue_valid), 64'd1);
        step();

        // Same-cycle capture at push time
        cdb_valid = 1'b1; cdb_tag = 6'd12; cdb_data = 32'hAA;
        push(32'h11, 6'd0, 1'b1, 32'd0, 6'd12, 1'b0, 6'd5, 1'b1, 32'h11, 32'hAA);
        cdb_valid = 1'b0;
        step();

        // One broadcast wakes both operands
        push(32'd0, 6'd20, 1'b0, 32'd0, 6'd20, 1'b0, 6'd6, 1'b1, 32'h55, 32'h55);
        cdb_valid = 1'b1; cdb_tag = 6'd20; cdb_data = 32'h55;
        step();
        cdb_valid = 1'b0;
        chk("both_woken", 64'(issue_valid), 64'd1);
        step();

        // Fill, refuse, refuse under pop, then wrap with push/pop pairs
        exec_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(32'(i), 6'd0, 1'b1, 32'(i + 100), 6'd0, 1'b1, 6'(i), 1'b1, 32'(i), 32'(i + 100));
            chk("fill_full", 64'(queue_full), (i == 3) ? 64'd1 : 64'd0);
        end
        push(32'hBAD, 6'd0, 1'b1, 32'hBAD, 6'd0, 1'b1, 6'h3F, 1'b0, 32'd0, 32'd0);
        chk("full_after_refuse", 64'(queue_full), 64'd1);
        exec_ready = 1'b1;
        push(32'hBAD, 6'd0, 1'b1, 32'hBAD, 6'd0, 1'b1, 6'h3E, 1'b0, 32'd0, 32'd0);
        chk("refused_under_pop", 64'(queue_full), 64'd0);
        for (int i = 4; i < 10; i++) begin
            push(32'(i), 6'd0, 1'b1, 32'(i + 100), 6'd0, 1'b1, 6'(i), 1'b1, 32'(i), 32'(i + 100));
        end
        repeat (4) step();
        chk("drained", 64'(sbq.size()), 64'd0);

        // Flush with three entries and a concurrent push
        exec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(32'(i + 7), 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 6'(i + 20), 1'b0, 32'd0, 32'd0);
        end
        flush = 1'b1; exec_ready = 1'b1; dispatch_en = 1'b1; d_rd_tag = 6'd23;
        d_rs1_valid = 1'b1; d_rs2_valid = 1'b1;
        #1;
        chk("flush_cycle_head", 64'(issue_valid), 64'd1);
        step();
        flush = 1'b0; dispatch_en = 1'b0; exec_ready = 1'b0;
        d_rs1_valid = 1'b0; d_rs2_valid = 1'b0;
        chk("flush_issue_valid", 64'(issue_valid), 64'd0);
        chk("flush_full", 64'(queue_full), 64'd0);
        for (int i = 0; i < 4; i++) begin
            push(32'(i + 30), 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 6'(i + 30), 1'b1, 32'(i + 30), 32'd2);
            chk("refill_full", 64'(queue_full), (i == 3) ? 64'd1 : 64'd0);
        end
        exec_ready = 1'b1;
        repeat (5) step();

`ifdef MULT_IQ_BYPASS_EN
        d_rs1_data = 32'd8; d_rs2_data = 32'd9; d_rs1_valid = 1'b1; d_rs2_valid = 1'b1;
        d_rd_tag = 6'd40; dispatch_en = 1'b1;
        begin
            exp_t e;
            e.rs1 = 32'd8; e.rs2 = 32'd9; e.rd = 6'd40;
            sbq.push_back(e);
        end
        #1;
        chk("bypass_same_cycle", 64'(issue_valid), 64'd1);
        step();
        dispatch_en = 1'b0; d_rs1_valid = 1'b0; d_rs2_valid = 1'b0;
        step();
`endif

        // Async reset in the middle of traffic
        exec_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(32'(i), 6'd0, 1'b1, 32'(i), 6'd0, 1'b1, 6'(i + 50), 1'b0, 32'd0, 32'd0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_issue_valid", 64'(issue_valid), 64'd0);
        chk("midrst_full", 64'(queue_full), 64'd0);
        step();
        rst_n = 1'b1;
        exec_ready = 1'b1;
        push(32'h77, 6'd0, 1'b1, 32'h88, 6'd0, 1'b1, 6'd60, 1'b1, 32'h77, 32'h88);
        repeat (3) step();
        chk("final_drained", 64'(sbq.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
